// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl
// Framing controller that sits behind a UART byte receiver. It hunts for a
// sync byte, then takes LEN, LEN payload bytes and an XOR checksum. The payload
// is kept in an internal buffer, and each good packet is offered to the
// application, which reads it through a registered random-access port.
// Length, checksum, inter-byte timeout and overrun conditions raise one-cycle
// error pulses.
//
// Optional build macro: PKT_STATS_EN adds saturating o_good_cnt / o_err_cnt.
//
// Packet handshake: o_pkt_valid rises one cycle after a correct CHK byte. It
// stays high, with o_pkt_len and the buffer frozen, until i_pkt_ack is sampled
// high on a clock edge. The controller is back in HUNT on the following cycle.
// i_pkt_ack while o_pkt_valid is low has no effect. Any byte that arrives
// while a packet is held, including one in the same cycle as the ack, is
// dropped and flagged on o_overrun.
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 4340
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_rx_valid,
    input  logic [7:0]                   i_rx_byte,
    output logic                         o_pkt_valid,
    input  logic                         i_pkt_ack,
    output logic [$clog2(MAX_LEN+1)-1:0] o_pkt_len,
    input  logic [$clog2(MAX_LEN)-1:0]   i_rd_addr,
    output logic [7:0]                   o_rd_data,
    output logic                         o_len_err,
    output logic                         o_chk_err,
    output logic                         o_timeout,
    output logic                         o_overrun,
    output logic [2:0]                   o_dbg_state
`ifdef PKT_STATS_EN
    ,
    output logic [15:0]                  o_good_cnt,
    output logic [15:0]                  o_err_cnt
`endif
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam int              TMO_LAST_I = TIMEOUT_CYCLES - 1;
    localparam logic [TW-1:0]   TMO_LAST   = TMO_LAST_I[TW-1:0];
    localparam logic [7:0]      MAX_LEN_B  = MAX_LEN[7:0];
    localparam logic [AW:0]     DEPTH      = MAX_LEN[AW:0];

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    state_t        state;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [7:0]    chk_q;
    logic [TW-1:0] tmo_cnt;

    logic [7:0]    buffer [MAX_LEN];

    logic          in_frame;
    logic          tmo_hit;
    logic          len_bad;
    logic          chk_ok;
    logic          last_payload;

    // Frame decode helpers. The LEN test uses the full byte, before it is
    // truncated to the length width.
    assign in_frame     = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    assign tmo_hit      = (tmo_cnt == TMO_LAST);
    assign len_bad      = (i_rx_byte == 8'd0) || (i_rx_byte > MAX_LEN_B);
    assign chk_ok       = (i_rx_byte == chk_q);
    assign last_payload = (idx_q == (len_q - LW'(1)));

    assign o_dbg_state  = state;

    // Framing FSM with registered packet status and one-cycle error pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_HUNT;
            len_q       <= '0;
            idx_q       <= '0;
            chk_q       <= '0;
            tmo_cnt     <= '0;
            o_pkt_valid <= 1'b0;
            o_pkt_len   <= '0;
            o_len_err   <= 1'b0;
            o_chk_err   <= 1'b0;
            o_timeout   <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_len_err <= 1'b0;
            o_chk_err <= 1'b0;
            o_timeout <= 1'b0;
            o_overrun <= 1'b0;

            // Inter-byte watchdog. It only acts when no byte arrives, so a
            // byte that lands on the expiry cycle always wins.
            if (in_frame) begin
                if (i_rx_valid) begin
                    tmo_cnt <= '0;
                end else if (tmo_hit) begin
                    tmo_cnt   <= '0;
                    o_timeout <= 1'b1;
                    state     <= ST_HUNT;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                ST_HUNT: begin
                    if (i_rx_valid && (i_rx_byte == SYNC_BYTE)) begin
                        state <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (i_rx_valid) begin
                        if (len_bad) begin
                            o_len_err <= 1'b1;
                            state     <= ST_HUNT;
                        end else begin
                            len_q <= i_rx_byte[LW-1:0];
                            chk_q <= i_rx_byte;
                            idx_q <= '0;
                            state <= ST_PAYLOAD;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (i_rx_valid) begin
                        chk_q <= chk_q ^ i_rx_byte;
                        idx_q <= idx_q + LW'(1);
                        if (last_payload) begin
                            state <= ST_CHK;
                        end
                    end
                end

                ST_CHK: begin
                    if (i_rx_valid) begin
                        if (chk_ok) begin
                            o_pkt_valid <= 1'b1;
                            o_pkt_len   <= len_q;
                            state       <= ST_HOLD;
                        end else begin
                            o_chk_err <= 1'b1;
                            state     <= ST_HUNT;
                        end
                    end
                end

                ST_HOLD: begin
                    if (i_rx_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (i_pkt_ack) begin
                        o_pkt_valid <= 1'b0;
                        state       <= ST_HUNT;
                    end
                end

                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

    // Payload store. Writes only happen in PAYLOAD, so a held packet is never
    // disturbed. The contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if ((state == ST_PAYLOAD) && i_rx_valid) begin
            buffer[idx_q[AW-1:0]] <= i_rx_byte;
        end
    end

    // Registered read port. Addresses beyond the buffer keep the previous data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_data <= 8'h00;
        end else if ({1'b0, i_rd_addr} < DEPTH) begin
            o_rd_data <= buffer[i_rd_addr];
        end
    end

`ifdef PKT_STATS_EN
    logic good_accept;
    logic any_err;

    assign good_accept = (state == ST_CHK) && i_rx_valid && chk_ok;
    assign any_err     = o_len_err || o_chk_err || o_timeout;

    // Saturating counters of accepted packets and framing errors (overrun excluded)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_good_cnt <= 16'h0000;
            o_err_cnt  <= 16'h0000;
        end else begin
            if (good_accept && (o_good_cnt != 16'hFFFF)) begin
                o_good_cnt <= o_good_cnt + 16'd1;
            end
            if (any_err && (o_err_cnt != 16'hFFFF)) begin
                o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// tb_uart_rx_packet_ctrl
// Directed and randomized framing scenarios for uart_rx_packet_ctrl. Inputs
// change on the falling edge, and outputs are inspected on the falling edge
// after the rising edge that produced them.
module tb_uart_rx_packet_ctrl;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 4340;
    localparam int         LW      = $clog2(MAX_LEN + 1);
    localparam int         AW      = $clog2(MAX_LEN);

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          pkt_valid;
    logic          pkt_ack;
    logic [LW-1:0] pkt_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          len_err;
    logic          chk_err;
    logic          timeout;
    logic          overrun;
    logic [2:0]    dbg_state;
`ifdef PKT_STATS_EN
    logic [15:0]   good_cnt;
    logic [15:0]   err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: payload bytes expected from the held packet, in address order
    logic [7:0] exp_q[$];

    // Expected and observed pulse totals
    int exp_len = 0, exp_chk = 0, exp_tmo = 0, exp_ovr = 0;
    int obs_len = 0, obs_chk = 0, obs_tmo = 0, obs_ovr = 0;
    int exp_good = 0, exp_errs = 0;

    uart_rx_packet_ctrl #(
        .SYNC_BYTE      (SYNC),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_valid  (rx_valid),
        .i_rx_byte   (rx_byte),
        .o_pkt_valid (pkt_valid),
        .i_pkt_ack   (pkt_ack),
        .o_pkt_len   (pkt_len),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_len_err   (len_err),
        .o_chk_err   (chk_err),
        .o_timeout   (timeout),
        .o_overrun   (overrun),
        .o_dbg_state (dbg_state)
`ifdef PKT_STATS_EN
        ,
        .o_good_cnt  (good_cnt),
        .o_err_cnt   (err_cnt)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: one count per cycle each pulse is high
    always @(posedge clk) begin
        if (len_err) obs_len++;
        if (chk_err) obs_chk++;
        if (timeout) obs_tmo++;
        if (overrun) obs_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One strobe; on return the response to this byte is visible
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom_range(0, 255));
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    task automatic read_check(input int addr, input logic [7:0] exp, input string tag);
        rd_addr = AW'(addr);
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    task automatic ack_pkt(input bit with_byte, input logic [7:0] b);
        pkt_ack = 1'b1;
        if (with_byte) begin
            rx_valid = 1'b1;
            rx_byte  = b;
        end
        @(negedge clk);
        pkt_ack  = 1'b0;
        rx_valid = 1'b0;
        check("ack_drops_valid", pkt_valid, 0);
        if (with_byte) begin
            check("ack_coincident_overrun", overrun, 1);
            exp_ovr++;
        end
    endtask

    task automatic check_counts(input string tag);
        idle(1);
        check({tag, "_len_err_cnt"}, obs_len, exp_len);
        check({tag, "_chk_err_cnt"}, obs_chk, exp_chk);
        check({tag, "_timeout_cnt"}, obs_tmo, exp_tmo);
        check({tag, "_overrun_cnt"}, obs_ovr, exp_ovr);
    endtask

    // Random frame: kind decides good / bad checksum / bad length, and the
    // expected outcome follows from the frame rules alone.
    task automatic random_frame();
        int         kind;
        int         n_junk;
        int         n_ovr;
        logic [7:0] len;
        logic [7:0] sum;
        logic [7:0] b;
        logic [7:0] pay[$];

        kind   = $urandom_range(0, 9);
        n_junk = $urandom_range(0, 2);
        for (int j = 0; j < n_junk; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h00;
            send_byte(b);
            idle($urandom_range(0, 2));
        end

        send_byte(SYNC);
        idle($urandom_range(0, 3));

        if (kind >= 8) begin
            len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
            send_byte(len);
            check("rnd_len_err", len_err, 1);
            exp_len++;
            exp_errs++;
            return;
        end

        len = 8'($urandom_range(1, MAX_LEN));
        sum = len;
        send_byte(len);
        for (int k = 0; k < int'(len); k++) begin
            idle($urandom_range(0, 3));
            b = 8'($urandom_range(0, 255));
            pay.push_back(b);
            sum = sum ^ b;
            send_byte(b);
        end
        idle($urandom_range(0, 3));

        if (kind >= 6) begin
            send_byte(sum ^ 8'($urandom_range(1, 255)));
            check("rnd_chk_err", chk_err, 1);
            check("rnd_bad_no_valid", pkt_valid, 0);
            exp_chk++;
            exp_errs++;
            return;
        end

        send_byte(sum);
        check("rnd_pkt_valid", pkt_valid, 1);
        check("rnd_pkt_len", pkt_len, len[LW-1:0]);
        exp_good++;
        foreach (pay[i]) exp_q.push_back(pay[i]);

        n_ovr = $urandom_range(0, 2);
        for (int j = 0; j < n_ovr; j++) begin
            idle($urandom_range(0, 2));
            send_byte(8'($urandom_range(0, 255)));
            check("rnd_overrun", overrun, 1);
            exp_ovr++;
        end

        for (int a = 0; a < int'(len); a++) begin
            read_check(a, exp_q.pop_front(), "rnd_rd_data");
        end
        check("rnd_still_valid", pkt_valid, 1);

        if ($urandom_range(0, 1) == 1) ack_pkt(1'b1, 8'($urandom_range(0, 255)));
        else                           ack_pkt(1'b0, 8'h00);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        pkt_ack  = 1'b0;
        rd_addr  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_len_err", len_err, 0);
        check("rst_chk_err", chk_err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_overrun", overrun, 0);
`ifdef PKT_STATS_EN
        check("rst_good_cnt", good_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
`endif
        rst = 1'b0;
        idle(1);

        // Good 3-byte frame; 03^11^22^33 works out to 03
        send_bytes('{SYNC, 8'h03, 8'h11, 8'h22, 8'h33});
        check("good_not_valid_before_chk", pkt_valid, 0);
        send_byte(8'h03);
        check("good_valid", pkt_valid, 1);
        check("good_len", pkt_len, 3);
        read_check(0, 8'h11, "good_rd0");
        read_check(1, 8'h22, "good_rd1");
        read_check(2, 8'h33, "good_rd2");
        ack_pkt(1'b0, 8'h00);
        exp_good++;

        // Bad checksum, then a good frame back-to-back
        send_bytes('{SYNC, 8'h02, 8'h10, 8'h20, 8'hFF});
        check("chk_err_pulse", chk_err, 1);
        check("chk_err_no_valid", pkt_valid, 0);
        exp_chk++;
        exp_errs++;
        send_byte(SYNC);
        check("chk_err_one_cycle", chk_err, 0);
        send_bytes('{8'h01, 8'h5A, 8'h5B});
        check("after_chk_err_valid", pkt_valid, 1);
        read_check(0, 8'h5A, "after_chk_err_rd0");
        ack_pkt(1'b0, 8'h00);
        exp_good++;

        // Length errors at both ends, then a 1-byte frame
        send_bytes('{SYNC, 8'h00});
        check("len_zero_err", len_err, 1);
        send_bytes('{SYNC, 8'h11});
        check("len_over_err", len_err, 1);
        exp_len += 2;
        exp_errs += 2;
        send_bytes('{SYNC, 8'h01, 8'h7E, 8'h7F});
        check("after_len_err_valid", pkt_valid, 1);
        check("after_len_err_len", pkt_len, 1);
        read_check(0, 8'h7E, "after_len_err_rd0");
        ack_pkt(1'b0, 8'h00);
        exp_good++;

        // Inter-byte timeout mid-payload
        send_bytes('{SYNC, 8'h02, 8'hAA});
        idle(TMO - 1);
        check("tmo_not_yet", timeout, 0);
        idle(1);
        check("tmo_pulse", timeout, 1);
        exp_tmo++;
        exp_errs++;
        idle(1);
        check("tmo_one_cycle", timeout, 0);

        // Byte landing on the expiry cycle wins
        send_bytes('{SYNC, 8'h02, 8'hAA});
        idle(TMO - 1);
        send_byte(8'hBB);
        check("tmo_boundary_suppressed", timeout, 0);
        send_byte(8'h13);
        check("tmo_boundary_valid", pkt_valid, 1);
        read_check(1, 8'hBB, "tmo_boundary_rd1");
        ack_pkt(1'b0, 8'h00);
        exp_good++;

        // Overrun while held; buffer untouched; byte with ack dropped
        send_bytes('{SYNC, 8'h02, 8'hC3, 8'h3C, 8'hFD});
        check("ovr_valid", pkt_valid, 1);
        exp_good++;
        send_byte(SYNC);
        check("ovr_pulse0", overrun, 1);
        send_byte(8'h02);
        check("ovr_pulse1", overrun, 1);
        send_byte(8'h00);
        check("ovr_pulse2", overrun, 1);
        exp_ovr += 3;
        check("ovr_len_kept", pkt_len, 2);
        read_check(0, 8'hC3, "ovr_rd0");
        read_check(1, 8'h3C, "ovr_rd1");
        ack_pkt(1'b1, SYNC);
        send_byte(8'h00);
        check("ack_sync_not_taken", len_err, 0);
        check_counts("directed");

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            random_frame();
            check_counts("random");
            idle($urandom_range(0, 5));
        end
`ifdef PKT_STATS_EN
        check("stats_good_cnt", good_cnt, exp_good);
        check("stats_err_cnt", err_cnt, exp_errs);
`endif

        // Reset mid-payload clears outputs without waiting for a clock edge
        rd_addr = '0;
        send_bytes('{SYNC, 8'h04, 8'h01, 8'h02});
        check("pre_rst_rd_data", rd_data, 8'h01);
        check("pre_rst_pkt_len", pkt_len, exp_good > 0 ? 32'(pkt_len) : 32'(0));
        #2 rst = 1'b1;
        #1;
        check("async_rst_rd_data", rd_data, 0);
        check("async_rst_pkt_len", pkt_len, 0);
        check("async_rst_pkt_valid", pkt_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_good = 0;
        exp_errs = 0;
        idle(1);
        send_bytes('{SYNC, 8'h01, 8'h44, 8'h45});
        check("post_rst_valid", pkt_valid, 1);
        read_check(0, 8'h44, "post_rst_rd0");
        exp_good++;
`ifdef PKT_STATS_EN
        check("post_rst_good_cnt", good_cnt, 1);
        check("post_rst_err_cnt", err_cnt, 0);
`endif
        ack_pkt(1'b0, 8'h00);
        check_counts("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
